cpu_memory_stage: RTL and testbench
===================================

Name: cpu_memory_stage

Overview:
- Pipeline stage directly upstream of the writeback stage.
- Takes execute-stage results and performs any data load or store over a simple request/ready bus.
- Produces the 39-bit writeback word {strobe, rd[5:0], rd_value[31:0]}.
- A toggle on the strobe bit marks each retired instruction; the writeback stage counts these toggles as retirements.

Parameters:
- ADDR_W, 32, data bus address width.
- XLEN, 32, register and data width.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_data  in  110  execute result: [109] strobe, [108:103] rd, [102:71] rd_value, [70:39] mem_address, [38] mem_read, [37] mem_write, [36:35] mem_width (0=byte, 1=half, 2=word), [34] mem_signed, [33:2] mem_wdata, [1:0] reserved
- o_data  out  39  [38] strobe, [37:32] rd, [31:0] rd_value
- o_busy  out  1  stall upstream: high while a bus access is outstanding
- o_bus_request  out  1  bus access request
- o_bus_rw  out  1  1 = write
- o_bus_address  out  32  word-aligned address
- o_bus_wdata  out  32  lane-shifted store data
- o_bus_wmask  out  4  byte enables
- i_bus_rdata  in  32  read data
- i_bus_ready  in  1  access complete this cycle

Behaviour:
- Reset values: all outputs 0, last_strobe 0, FSM in IDLE.
- New instruction detected when i_data[109] != last_strobe. last_strobe updates only when the instruction is accepted.
- FSM states: IDLE, ACCESS.
- IDLE, new instruction, no memory op:
  - Next cycle: o_data = {i_data[109], rd, rd_value}.
  - Latency is 1 cycle.
- IDLE, new instruction, mem_read or mem_write:
  - Latch all fields.
  - Drive o_bus_request=1, o_bus_address = {addr[31:2], 2'b00}.
  - Set o_busy=1 and move to ACCESS.
- ACCESS:
  - Hold all bus outputs stable until i_bus_ready=1.
  - On ready: deassert request and o_busy, update o_data, toggle the output strobe, return to IDLE.
  - Load latency is 1 + bus wait cycles.
- Upstream holds i_data stable while o_busy=1.
- Store lanes:
  - byte: wdata[7:0] replicated to all four lanes, wmask = 1 << addr[1:0].
  - half: wdata[15:0] replicated, wmask = addr[1] ? 4'b1100 : 4'b0011.
  - word: wmask = 4'b1111.
- Store result: o_data rd_value = latched rd_value (stores normally carry rd=0).
- Load extraction:
  - Select byte/half by addr[1:0] / addr[1].
  - Sign-extend if mem_signed=1, else zero-extend.
  - Word passes through unchanged.
- Both mem_read and mem_write set: treat as a write.
- i_bus_ready while in IDLE: ignored.
- Reset mid-access: request drops the next cycle and no strobe toggle is issued.
- Back-to-back instructions: one accepted per cycle when no bus access is in flight.

Optional Feature:
- Macro: CPU_MEMORY_STAGE_MISALIGN_FAULT_EN.
- Defined, misaligned access (half with addr[0]=1, or word with addr[1:0]!=0):
  - No bus request is issued.
  - New port o_fault (1 bit) pulses high for 1 cycle.
  - o_data toggles strobe with rd forced to 0 (instruction retires, no register write).
  - Latency is 1 cycle.
- Not defined: no o_fault port; low address bits are ignored for lane selection beyond the width rules above, and the access proceeds.

Decomposition:
- Shared package cpu_pkg holds:
  - mem_width enum (BYTE, HALF, WORD).
  - Packed structs for the execute→memory (110-bit) and memory→writeback (39-bit) words.
  - The state enum.
- Sub-module cpu_memory_lane holds the purely combinational lane logic: store shift plus mask, load extract plus extend.

Test Plan:
- ALU op: rd=5, value=0x1234, strobe toggles → 1 cycle later o_data={1,5,0x1234}, o_bus_request stays 0.
- Load byte signed: addr=0x103, rdata=0x80FF_FF7F → wait for ready (3 wait cycles) → rd_value=0xFFFF_FF80, o_busy high 4 cycles, strobe toggles once.
- Store half: addr=0x202, wdata=0xABCD → o_bus_address=0x200, wmask=4'b1100, o_bus_wdata=0xABCD_ABCD, o_bus_rw=1.
- Load word, then ALU op presented during ACCESS → ALU result appears only after ready; two strobe toggles total, in order.
- Reset asserted during ACCESS → next cycle o_bus_request=0, o_data=0, no toggle.
- With CPU_MEMORY_STAGE_MISALIGN_FAULT_EN: load word at 0x101 → o_fault one-cycle pulse, no request, o_data rd=0 with strobe toggled.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types for the execute/memory/writeback pipeline words
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_width_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Execute -> memory word, 110 bits, MSB first.
    typedef struct packed {
        logic              strobe;
        logic [5:0]        rd;
        logic [WORD_W-1:0] rd_value;
        logic [WORD_W-1:0] mem_address;
        logic              mem_read;
        logic              mem_write;
        mem_width_t        mem_width;
        logic              mem_signed;
        logic [WORD_W-1:0] mem_wdata;
        logic [1:0]        reserved;
    } ex_mem_t;

    // Memory -> writeback word, 39 bits.
    typedef struct packed {
        logic              strobe;
        logic [5:0]        rd;
        logic [WORD_W-1:0] rd_value;
    } mem_wb_t;

    function automatic logic is_misaligned(input mem_width_t width, input logic [1:0] offset);
        case (width)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return offset[0];
            default:  return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/cpu_memory_lane.sv
// rtl/cpu_memory_lane.sv - combinational store lane shift/mask and load extract/extend
module cpu_memory_lane
    import cpu_pkg::*;
(
    input  mem_width_t        width,
    input  logic [1:0]        offset,
    input  logic              is_signed,
    input  logic [WORD_W-1:0] store_data,
    input  logic [WORD_W-1:0] load_word,
    output logic [WORD_W-1:0] bus_wdata,
    output logic [3:0]        bus_wmask,
    output logic [WORD_W-1:0] load_value
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = load_word[{offset, 3'b000} +: 8];
        sel_half = offset[1] ? load_word[31:16] : load_word[15:0];
        case (width)
            MEM_BYTE: begin
                bus_wdata  = {4{store_data[7:0]}};
                bus_wmask  = 4'b0001 << offset;
                load_value = {{24{is_signed & sel_byte[7]}}, sel_byte};
            end
            MEM_HALF: begin
                bus_wdata  = {2{store_data[15:0]}};
                bus_wmask  = offset[1] ? 4'b1100 : 4'b0011;
                load_value = {{16{is_signed & sel_half[15]}}, sel_half};
            end
            default: begin
                bus_wdata  = store_data;
                bus_wmask  = 4'b1111;
                load_value = load_word;
            end
        endcase
    end

endmodule

// File: rtl/cpu_memory_stage.sv
// rtl/cpu_memory_stage.sv - memory pipeline stage; CPU_MEMORY_STAGE_MISALIGN_FAULT_EN adds o_fault
module cpu_memory_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [109:0]      i_data,
    output logic [38:0]       o_data,
    output logic              o_busy,
`ifdef CPU_MEMORY_STAGE_MISALIGN_FAULT_EN
    output logic              o_fault,
`endif
    output logic              o_bus_request,
    output logic              o_bus_rw,
    output logic [ADDR_W-1:0] o_bus_address,
    output logic [XLEN-1:0]   o_bus_wdata,
    output logic [3:0]        o_bus_wmask,
    input  logic [XLEN-1:0]   i_bus_rdata,
    input  logic              i_bus_ready
);

    ex_mem_t    in_word;
    ex_mem_t    held;
    mem_wb_t    wb;
    state_t     state;
    logic       last_strobe;
    logic       new_instr;
    logic       mem_op;

    mem_width_t        lane_width;
    logic [1:0]        lane_offset;
    logic              lane_signed;
    logic [WORD_W-1:0] lane_store;
    logic [WORD_W-1:0] lane_wdata;
    logic [3:0]        lane_wmask;
    logic [WORD_W-1:0] lane_load;
    logic              unused_bits;

    assign in_word   = i_data;
    assign o_data    = wb;
    assign new_instr = (state == ST_IDLE) && (in_word.strobe != last_strobe);
    assign mem_op    = in_word.mem_read | in_word.mem_write;

    // Stores shape lanes from the incoming word; loads extract using the latched copy.
    assign lane_width  = (state == ST_IDLE) ? in_word.mem_width        : held.mem_width;
    assign lane_offset = (state == ST_IDLE) ? in_word.mem_address[1:0] : held.mem_address[1:0];
    assign lane_signed = (state == ST_IDLE) ? in_word.mem_signed       : held.mem_signed;
    assign lane_store  = (state == ST_IDLE) ? in_word.mem_wdata        : held.mem_wdata;

    assign unused_bits = ^{held.mem_address[WORD_W-1:2], held.mem_read, held.reserved, in_word.reserved};

    cpu_memory_lane u_lane (
        .width      (lane_width),
        .offset     (lane_offset),
        .is_signed  (lane_signed),
        .store_data (lane_store),
        .load_word  (i_bus_rdata),
        .bus_wdata  (lane_wdata),
        .bus_wmask  (lane_wmask),
        .load_value (lane_load)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            last_strobe   <= 1'b0;
            held          <= '0;
            wb            <= '0;
            o_busy        <= 1'b0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            o_bus_wmask   <= '0;
`ifdef CPU_MEMORY_STAGE_MISALIGN_FAULT_EN
            o_fault       <= 1'b0;
`endif
        end else begin
`ifdef CPU_MEMORY_STAGE_MISALIGN_FAULT_EN
            o_fault <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (new_instr) begin
                        last_strobe <= in_word.strobe;
                        if (!mem_op) begin
                            wb <= '{strobe: in_word.strobe, rd: in_word.rd, rd_value: in_word.rd_value};
                        end
`ifdef CPU_MEMORY_STAGE_MISALIGN_FAULT_EN
                        else if (is_misaligned(in_word.mem_width, in_word.mem_address[1:0])) begin
                            wb      <= '{strobe: in_word.strobe, rd: 6'd0, rd_value: in_word.rd_value};
                            o_fault <= 1'b1;
                        end
`endif
                        else begin
                            held          <= in_word;
                            o_busy        <= 1'b1;
                            o_bus_request <= 1'b1;
                            o_bus_rw      <= in_word.mem_write;
                            o_bus_address <= {in_word.mem_address[ADDR_W-1:2], 2'b00};
                            o_bus_wdata   <= in_word.mem_write ? lane_wdata : '0;
                            o_bus_wmask   <= in_word.mem_write ? lane_wmask : 4'b0000;
                            state         <= ST_ACCESS;
                        end
                    end
                end
                default: begin
                    if (i_bus_ready) begin
                        wb <= '{strobe: held.strobe, rd: held.rd,
                                rd_value: held.mem_write ? held.rd_value : lane_load};
                        o_busy        <= 1'b0;
                        o_bus_request <= 1'b0;
                        o_bus_rw      <= 1'b0;
                        o_bus_address <= '0;
                        o_bus_wdata   <= '0;
                        o_bus_wmask   <= '0;
                        state         <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_memory_stage.sv
// tb/tb_cpu_memory_stage.sv - self-checking bench for cpu_memory_stage
module tb_cpu_memory_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [109:0] in_data;
    logic [38:0]  out_data;
    logic         busy;
`ifdef CPU_MEMORY_STAGE_MISALIGN_FAULT_EN
    logic         fault;
`endif
    logic         req;
    logic         rw;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [3:0]   bus_wmask;
    logic [31:0]  rdata;
    logic         ready;

    int           compared   = 0;
    int           mismatched = 0;
    logic         strobe_q   = 1'b0;
    logic [38:0]  exp_out    = '0;

    always #5 clk = ~clk;

    cpu_memory_stage dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_data        (in_data),
        .o_data        (out_data),
        .o_busy        (busy),
`ifdef CPU_MEMORY_STAGE_MISALIGN_FAULT_EN
        .o_fault       (fault),
`endif
        .o_bus_request (req),
        .o_bus_rw      (rw),
        .o_bus_address (bus_addr),
        .o_bus_wdata   (bus_wdata),
        .o_bus_wmask   (bus_wmask),
        .i_bus_rdata   (rdata),
        .i_bus_ready   (ready)
    );

    task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [109:0] mk(input logic s, input logic [5:0] rd, input logic [31:0] v,
                                        input logic [31:0] a, input logic r, input logic w,
                                        input logic [1:0] wd, input logic sg, input logic [31:0] sd);
        return {s, rd, v, a, r, w, wd, sg, sd, 2'b00};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] wd, input logic sg,
                                             input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        if (wd == 2'd0) begin
            r = (d >> ((a % 4) * 8)) & 32'hFF;
            if (sg && r >= 32'd128) r = r - 32'd256;
        end else if (wd == 2'd1) begin
            r = (d >> (((a / 2) % 2) * 16)) & 32'hFFFF;
            if (sg && r >= 32'd32768) r = r - 32'd65536;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_mask(input logic [1:0] wd, input logic [31:0] a);
        if (wd == 2'd0) return 4'(1 << (a % 4));
        if (wd == 2'd1) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] wd, input logic [31:0] sd);
        if (wd == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
        if (wd == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] wd, input logic [31:0] a);
        return (wd == 2'd1 && (a % 2) != 0) || (wd == 2'd2 && (a % 4) != 0);
    endfunction

    task automatic alu(input logic [5:0] rd, input logic [31:0] v);
        strobe_q = ~strobe_q;
        in_data  = mk(strobe_q, rd, v, $urandom, 1'b0, 1'b0, 2'($urandom_range(0, 2)), 1'($urandom), $urandom);
        exp_out  = {strobe_q, rd, v};
        @(negedge clk);
        check("alu_data", out_data, exp_out);
        check("alu_req", req, 0);
        check("alu_busy", busy, 0);
    endtask

    task automatic mem(input logic is_rd, input logic is_wr, input logic [1:0] wd, input logic sg,
                       input logic [31:0] a, input logic [31:0] sd, input logic [5:0] rd,
                       input logic [31:0] v, input int waits, input logic [31:0] rdat);
        strobe_q = ~strobe_q;
        in_data  = mk(strobe_q, rd, v, a, is_rd, is_wr, wd, sg, sd);
        @(negedge clk);
`ifdef CPU_MEMORY_STAGE_MISALIGN_FAULT_EN
        if (ref_misaligned(wd, a)) begin
            exp_out = {strobe_q, 6'd0, v};
            check("mis_fault", fault, 1);
            check("mis_req", req, 0);
            check("mis_data", out_data, exp_out);
            @(negedge clk);
            check("mis_fault_clear", fault, 0);
        end else
`endif
        begin
            for (int i = 0; i <= waits; i++) begin
                check("acc_req", req, 1);
                check("acc_busy", busy, 1);
                check("acc_rw", rw, is_wr);
                check("acc_addr", bus_addr, a & 32'hFFFF_FFFC);
                check("acc_hold_data", out_data, exp_out);
                if (is_wr) begin
                    check("acc_wmask", bus_wmask, ref_mask(wd, a));
                    check("acc_wdata", bus_wdata, ref_wdata(wd, sd));
                end
                if (i == waits) begin
                    ready = 1'b1;
                    rdata = rdat;
                end else begin
                    rdata = $urandom;
                end
                @(negedge clk);
            end
            ready   = 1'b0;
            exp_out = {strobe_q, rd, is_wr ? v : ref_load(wd, sg, a, rdat)};
            check("done_data", out_data, exp_out);
            check("done_req", req, 0);
            check("done_busy", busy, 0);
        end
    endtask

    initial begin
        logic s1;
        rst     = 1'b1;
        in_data = '0;
        ready   = 1'b0;
        rdata   = '0;
        repeat (2) @(negedge clk);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_req", {req, rw, bus_addr}, 0);
        check("rst_wr", {bus_wdata, bus_wmask}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_toggle", out_data, 0);

        alu(6'd5, 32'h1234);
        mem(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 6'd3, 32'h0, 3, 32'h80FF_FF7F);
        mem(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'hABCD, 6'd0, 32'h77, 1, 32'h0);
        mem(1'b1, 1'b1, 2'd0, 1'b0, 32'h301, 32'h5A, 6'd0, 32'h9, 0, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) alu(6'(i + 10), $urandom);

        ready = 1'b1;
        rdata = $urandom;
        repeat (2) @(negedge clk);
        ready = 1'b0;
        check("idle_ready_data", out_data, exp_out);
        check("idle_ready_req", req, 0);

        // Load word with an ALU op arriving while the access is still outstanding.
        strobe_q = ~strobe_q;
        s1       = strobe_q;
        in_data  = mk(s1, 6'd7, 32'h0, 32'h400, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
        @(negedge clk);
        check("ovl_req", req, 1);
        strobe_q = ~strobe_q;
        in_data  = mk(strobe_q, 6'd8, 32'h55, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        check("ovl_hold", out_data, exp_out);
        ready = 1'b1;
        rdata = 32'hCAFE_F00D;
        @(negedge clk);
        ready = 1'b0;
        check("ovl_load", out_data, {s1, 6'd7, 32'hCAFE_F00D});
        @(negedge clk);
        exp_out = {strobe_q, 6'd8, 32'h55};
        check("ovl_alu", out_data, exp_out);

        // Reset while an access is in flight.
        strobe_q = ~strobe_q;
        in_data  = mk(strobe_q, 6'd9, 32'h0, 32'h500, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        check("pre_rst_req", req, 1);
        rst     = 1'b1;
        in_data = '0;
        @(negedge clk);
        rst      = 1'b0;
        strobe_q = 1'b0;
        exp_out  = '0;
        check("mid_rst_req", req, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        check("post_rst_data", out_data, 0);

        mem(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 6'd4, 32'h33, 1, 32'h1234_5678);
        mem(1'b1, 1'b0, 2'd1, 1'b1, 32'h203, 32'h0, 6'd6, 32'h0, 0, 32'h8001_7FFF);

        for (int n = 0; n < 40; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 2);
            if (kind == 0)
                alu(6'($urandom), $urandom);
            else
                mem(kind == 1, kind == 2, 2'($urandom_range(0, 2)), 1'($urandom), $urandom,
                    $urandom, 6'($urandom), $urandom, int'($urandom_range(0, 3)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
